// File: rtl/face_state_editor_if.sv
// Button inputs and registered display outputs of the face state editor.
// The design takes the slave modport; the driver of the buttons takes master.
interface face_state_editor_if;
    logic        btnUp;
    logic        btnDown;
    logic        btnLeft;
    logic        btnRight;
    logic        btnColour;
    logic        btnFace;
    logic [2:0]  faceSel;
    logic [3:0]  cursor;
    logic [26:0] faceColours;
    logic        cursorVisible;
    logic        editPulse;

    modport master (
        output btnUp, btnDown, btnLeft, btnRight, btnColour, btnFace,
        input  faceSel, cursor, faceColours, cursorVisible, editPulse
    );

    modport slave (
        input  btnUp, btnDown, btnLeft, btnRight, btnColour, btnFace,
        output faceSel, cursor, faceColours, cursorVisible, editPulse
    );
endinterface

// File: rtl/face_state_editor.sv
// Cube face editor: 6 faces x 9 stickers of 3-bit colour, cursor and face selection.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
module face_state_editor #(
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    face_state_editor_if.slave bus
);
    localparam logic [3:0] CentreIdx = 4'd4;

    // Button vector order doubles as action priority: bit 5 wins.
    logic [5:0]  btn_lvl;
    logic [5:0]  prev_q;
    logic [5:0]  rise;

    logic [2:0]  face_sel_q, face_sel_d;
    logic [3:0]  cursor_q, cursor_d;
    logic        edit_q, edit_d;
    logic        act_d;
    logic [26:0] faces_q [6];
    logic [26:0] cur_word;
    logic [26:0] edit_word;

    logic [2:0]  face_sel_out_q;
    logic [3:0]  cursor_out_q;
    logic [26:0] colours_out_q;
    logic        edit_pulse_q;

    logic row0, row2, col0, col2;

    assign btn_lvl  = {bus.btnFace, bus.btnColour, bus.btnUp,
                       bus.btnDown, bus.btnLeft, bus.btnRight};
    assign rise     = btn_lvl & ~prev_q;
    assign cur_word = faces_q[face_sel_q];

    assign row0 = (cursor_q < 4'd3);
    assign row2 = (cursor_q > 4'd5);
    assign col0 = (cursor_q == 4'd0) || (cursor_q == 4'd3) || (cursor_q == 4'd6);
    assign col2 = (cursor_q == 4'd2) || (cursor_q == 4'd5) || (cursor_q == 4'd8);

    // Candidate face word with only the sticker under the cursor advanced.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_sticker
            logic [2:0] code;
            logic [2:0] code_adv;
            assign code     = cur_word[3*gi +: 3];
            assign code_adv = (code >= 3'd1 && code <= 3'd5) ? code + 3'd1 : 3'd1;
            assign edit_word[3*gi +: 3] = (cursor_q == 4'(gi)) ? code_adv : code;
        end
    endgenerate

    always_comb begin
        face_sel_d = face_sel_q;
        cursor_d   = cursor_q;
        edit_d     = 1'b0;
        act_d      = 1'b0;
        if (rise[5]) begin
            face_sel_d = (face_sel_q == 3'd5) ? 3'd0 : face_sel_q + 3'd1;
            cursor_d   = CentreIdx;
            act_d      = 1'b1;
        end else if (rise[4]) begin
            // The centre sticker defines the face colour and cannot be edited.
            if (cursor_q != CentreIdx) begin
                edit_d = 1'b1;
                act_d  = 1'b1;
            end
        end else if (rise[3]) begin
            cursor_d = row0 ? cursor_q + 4'd6 : cursor_q - 4'd3;
            act_d    = 1'b1;
        end else if (rise[2]) begin
            cursor_d = row2 ? cursor_q - 4'd6 : cursor_q + 4'd3;
            act_d    = 1'b1;
        end else if (rise[1]) begin
            cursor_d = col0 ? cursor_q + 4'd2 : cursor_q - 4'd1;
            act_d    = 1'b1;
        end else if (rise[0]) begin
            cursor_d = col2 ? cursor_q - 4'd2 : cursor_q + 4'd1;
            act_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q         <= '1;
            face_sel_q     <= 3'd0;
            cursor_q       <= CentreIdx;
            edit_q         <= 1'b0;
            for (int f = 0; f < 6; f++) begin
                faces_q[f] <= {9{3'(f + 1)}};
            end
            face_sel_out_q <= 3'd0;
            cursor_out_q   <= CentreIdx;
            colours_out_q  <= 27'o111111111;
            edit_pulse_q   <= 1'b0;
        end else begin
            prev_q     <= btn_lvl;
            face_sel_q <= face_sel_d;
            cursor_q   <= cursor_d;
            edit_q     <= edit_d;
            if (edit_d) begin
                faces_q[face_sel_q] <= edit_word;
            end
            // Output stage lags the state by one cycle so editPulse aligns with the new colours.
            face_sel_out_q <= face_sel_q;
            cursor_out_q   <= cursor_q;
            colours_out_q  <= cur_word;
            edit_pulse_q   <= edit_q;
        end
    end

    assign bus.faceSel     = face_sel_out_q;
    assign bus.cursor      = cursor_out_q;
    assign bus.faceColours = colours_out_q;
    assign bus.editPulse   = edit_pulse_q;

`ifdef CURSOR_BLINK_EN
    logic [31:0] blink_cnt_q;
    logic        visible_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= 32'd0;
            visible_q   <= 1'b1;
        end else if (act_d) begin
            blink_cnt_q <= 32'd0;
            visible_q   <= 1'b1;
        end else if (blink_cnt_q == 32'(BLINK_CYCLES - 1)) begin
            blink_cnt_q <= 32'd0;
            visible_q   <= ~visible_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 32'd1;
        end
    end

    assign bus.cursorVisible = visible_q;
`else
    logic blink_cycles_unused;
    assign blink_cycles_unused = (BLINK_CYCLES > 0) ^ act_d;
    assign bus.cursorVisible   = 1'b1;
`endif
endmodule
